ysyx_23060096_ifu: RTL
======================

# ysyx_23060096_ifu

Parametrised instruction fetch unit replacing the free-running PC register of the single-cycle core. It issues fetch requests to instruction memory over a valid/ready handshake and buffers returned instructions with their PCs in a small FIFO. Instructions are delivered to decode over a valid/ready handshake. It accepts redirects from execute and a halt from decode (ebreak), sitting between instruction memory and the ContrGen/ImmGen decode stage.

## Interface
- XLEN, 32, PC/address width (≥ 3)
- RESET_PC, 32'h8000_0000, PC loaded at reset (XLEN bits)
- DEPTH, 2, instruction buffer entries; power of two, ≥ 2
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous active-low reset
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  XLEN  fetch address (current PC)
- imem_rsp_valid  in  1  response valid, in order, never back-pressured
- imem_rsp_data  in  32  fetched instruction
- inst_valid  out  1  FIFO head valid
- inst_ready  in  1  decode consumes head
- inst  out  32  head instruction
- inst_pc  out  XLEN  head PC
- redirect_valid  in  1  control-flow change
- redirect_pc  in  XLEN  new fetch PC
- halt  in  1  ebreak seen by decode
- halted  out  1  sticky halt status
- misalign_err  out  1  sticky; present only with IFU_ALIGN_CHECK_EN

## Operation
- States: FETCH (no request outstanding), WAIT (one request outstanding), HALT. At most one request is outstanding at any time.
- FETCH: imem_req_valid = (count < DEPTH). This is combinational from state and count. On req handshake: pc <= pc + 4, mod 2^XLEN (wraps silently); go to WAIT.
- WAIT: imem_req_valid = 0. On imem_rsp_valid:
  - if drop flag clear, push {pc_of_req, data} into FIFO;
  - clear drop; go to FETCH.
- FIFO: push on accepted response, pop on inst_valid & inst_ready. Simultaneous push and pop leaves count unchanged. A push never occurs when full, because a request is issued only if space exists.
- Redirect (not in HALT):
  - flush FIFO and set pc <= redirect_pc;
  - if in WAIT, or a req handshake occurs in the same cycle, set drop so that response is discarded;
  - a response arriving in the redirect cycle is discarded.
- Halt: enter HALT and flush FIFO; halted <= 1. Any outstanding response is absorbed and discarded. No further requests are issued. Exit only by reset.
- halt and redirect_valid in the same cycle: halt wins.
- Redirect while in HALT: ignored.
- Reset mid-transaction: state returns to FETCH with an empty FIFO. A late memory response after reset is outside the contract; the memory is reset by the same rstn.

## Timing
- Reset values: pc = RESET_PC, state FETCH, count 0, drop 0, imem_req_valid 0 while rstn low, inst_valid 0, halted 0, misalign_err 0.
- First request is asserted in the first cycle after rstn deasserts.
- Latency: request accepted at cycle N; response at cycle ≥ N+1; inst_valid at response cycle + 1. There is no bypass from response to inst.
- Redirect takes effect at the next edge. The next request carries redirect_pc in the following cycle, provided the unit is not waiting.
- inst and inst_pc are stable while inst_valid & !inst_ready.

## Configuration
- IFU_ALIGN_CHECK_EN defined:
  - a redirect with redirect_pc[1:0] != 0 sets misalign_err and enters HALT, with the same flush and drop rules as halt;
  - halted is also set.
- Undefined: the misalign_err port is absent; redirect_pc[1:0] are forced to 0.

## Structure
- Package ysyx_23060096_ifu_pkg: state enum (FETCH, WAIT, HALT), INST_W = 32, INST_BYTES = 4.
- Sub-module ysyx_23060096_ifu_fifo: synchronous FIFO with parameters DEPTH and entry width. It has push, pop, flush and count, and uses wrap-around pointers sized log2(DEPTH)+1.

## Test plan
- Reset, memory always ready, 1-cycle response, inst_ready=1 -> inst_pc sequence 8000_0000, 8000_0004, 8000_0008; first inst_valid in cycle 3 after reset release.
- inst_ready=0 with DEPTH=2 -> exactly 2 requests issued, then imem_req_valid stays 0. Asserting inst_ready resumes fetch.
- Redirect to 8000_0100 while in WAIT -> that response is dropped, FIFO is emptied, next request address is 8000_0100, and the next inst_pc is 8000_0100.
- halt with a response outstanding -> halted=1 next cycle, response discarded, inst_valid stays 0, and no further requests for 20 cycles.
- XLEN=32, RESET_PC=FFFF_FFFC -> second request address is 0000_0000.
- With IFU_ALIGN_CHECK_EN, redirect to 8000_0102 -> misalign_err=1, halted=1, and no further requests.

Source files
------------

// File: rtl/ysyx_23060096_ifu_pkg.sv
// Shared constants and FSM state encoding for the ysyx_23060096 instruction fetch unit.
package ysyx_23060096_ifu_pkg;

  localparam int INST_W     = 32;
  localparam int INST_BYTES = 4;

  typedef logic [1:0] ifu_state_t;

  localparam ifu_state_t FETCH = 2'd0;
  localparam ifu_state_t WAIT  = 2'd1;
  localparam ifu_state_t HALT  = 2'd2;

endpackage

// File: rtl/ysyx_23060096_ifu_fifo.sv
// Instruction buffer: synchronous FIFO with push, pop, flush and an occupancy count.
module ysyx_23060096_ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CW-1:0]    wr_q;
  logic [CW-1:0]    rd_q;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (flush_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem_q[rd_q[AW-1:0]];
  assign count_o = wr_q - rd_q;

endmodule

// File: rtl/ysyx_23060096_ifu.sv
// Instruction fetch unit: one outstanding imem request, buffered delivery to decode,
// redirect/halt handling. Optional IFU_ALIGN_CHECK_EN adds misaligned-redirect trapping.
module ysyx_23060096_ifu
  import ysyx_23060096_ifu_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            halted
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic            misalign_err
`endif
);

  localparam int EW = XLEN + INST_W;
  localparam int CW = $clog2(DEPTH) + 1;

  ifu_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            drop_q, drop_d;

  logic            push, pop, flush;
  logic [CW-1:0]   count;
  logic [EW-1:0]   head;
  logic            req_hs;
  logic            mis_go, halt_go, redirect_go;
  logic [XLEN-1:0] redirect_tgt;

`ifdef IFU_ALIGN_CHECK_EN
  assign mis_go       = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign redirect_tgt = redirect_pc;
`else
  assign mis_go       = 1'b0;
  assign redirect_tgt = redirect_pc & ~XLEN'(3);
`endif

  // Halt beats redirect; nothing but reset leaves HALT.
  assign halt_go     = (state_q != HALT) && (halt || mis_go);
  assign redirect_go = (state_q != HALT) && !halt_go && redirect_valid;
  assign flush       = halt_go || redirect_go;

  assign imem_req_valid = rstn && (state_q == FETCH) && (count != CW'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid && inst_ready;
  assign inst       = head[INST_W-1:0];
  assign inst_pc    = head[EW-1:INST_W];
  assign halted     = (state_q == HALT);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    drop_d   = drop_q;
    push     = 1'b0;
    if (halt_go) begin
      state_d = HALT;
    end else if (redirect_go) begin
      pc_d = redirect_tgt;
      // The in-flight response (or one launched this cycle) belongs to the old path.
      if (state_q == WAIT) begin
        if (imem_rsp_valid) begin
          state_d = FETCH;
          drop_d  = 1'b0;
        end else begin
          drop_d  = 1'b1;
        end
      end else if (req_hs) begin
        state_d  = WAIT;
        req_pc_d = pc_q;
        drop_d   = 1'b1;
      end
    end else begin
      case (state_q)
        FETCH: if (req_hs) begin
          pc_d     = pc_q + XLEN'(INST_BYTES);
          req_pc_d = pc_q;
          state_d  = WAIT;
        end
        WAIT: if (imem_rsp_valid) begin
          push    = !drop_q;
          drop_d  = 1'b0;
          state_d = FETCH;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= FETCH;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      drop_q   <= drop_d;
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  logic mis_err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                mis_err_q <= 1'b0;
    else if (halt_go && !halt) mis_err_q <= 1'b1;
  end

  assign misalign_err = mis_err_q;
`endif

  ysyx_23060096_ifu_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .data_i  ({req_pc_q, imem_rsp_data}),
    .data_o  (head),
    .count_o (count)
  );

endmodule
